// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_if
// Description : FIFO read side and UART line signals of fifo_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if;
    logic       empty;
    logic [7:0] q;
    logic       rdreq;
    logic       tx;
    logic       busy;
    logic       frame_done;

    // master is the UART block; slave is the FIFO / line side around it
    modport master (input empty, input q, output rdreq, output tx, output busy, output frame_done);
    modport slave  (output empty, output q, input rdreq, input tx, input busy, input frame_done);
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains a non-show-ahead byte FIFO into 8N1 UART frames.
//               Define UART_TX_PARITY_EN for 8E1 frames (even parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fifo_uart_tx_if.master bus
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_READ   = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd5;
`endif
    localparam logic [2:0] c_STOP   = 3'd6;

    localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);

    logic [2:0]  r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_frame_done;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif
    logic        w_bit_end;

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_baud_cnt   <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (!bus.empty) r_state <= c_READ;
                end
                c_READ: r_state <= c_WAIT;
                // q is valid now, one cycle after rdreq
                c_WAIT: begin
                    r_shift    <= bus.q;
`ifdef UART_TX_PARITY_EN
                    r_parity   <= ^bus.q;
`endif
                    r_tx       <= 1'b0;
                    r_baud_cnt <= 16'd0;
                    r_state    <= c_START;
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= r_shift[0];
                        r_state    <= c_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_shift    <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= c_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_tx       <= 1'b1;
                        r_state    <= c_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`endif
                c_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt   <= 16'd0;
                        r_frame_done <= 1'b1;
                        r_state      <= c_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.rdreq      = (r_state == c_READ);
    assign bus.busy       = (r_state != c_IDLE);
    assign bus.tx         = r_tx;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains the 8-bit AD sample FIFO of the polling controller and sends each byte as an asynchronous UART frame (8N1, LSB first) on a single TX line. It sits directly downstream of the polling controller and drives that block's `rdreq` from the controller's `empty` and `q`. The `0x0d`/`0x0a` terminators written by the controller pass through as ordinary bytes.

## Interface

Parameters:
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in baud.
- `BAUD_DIV`, default `CLK_FREQ/BAUD` (434): clocks per bit, truncated. Legal range is 2..65535.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: reset, synchronous, active-high.
- `empty`, in, 1: FIFO empty flag.
- `q`, in, 8: FIFO read data. Valid on the cycle after `rdreq` is high (non-show-ahead FIFO).
- `rdreq`, out, 1: FIFO read request. Asserted for exactly one cycle per byte.
- `tx`, out, 1: UART serial output. Idles high. Registered.
- `busy`, out, 1: high whenever the state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse when the stop bit completes.

## Operation

- States:
  - IDLE: `tx=1`. If `empty==0`, go to READ; otherwise stay.
  - READ: `rdreq=1`, decoded from the state register. Go to WAIT.
  - WAIT: latch `q` into the 8-bit shift register. Set `tx<=0`, clear `baud_cnt`, go to START.
  - START: hold `tx=0` for `BAUD_DIV` cycles, then go to DATA with `bit_idx=0` and `tx<=shift[0]`.
  - DATA: each bit is held for `BAUD_DIV` cycles. After each bit, shift right and increment `bit_idx`. After bit 7, go to STOP (or PARITY when the parity feature is compiled in) and drive the next line level.
  - STOP: hold `tx=1` for `BAUD_DIV` cycles. On the final count, pulse `frame_done` and go to IDLE.
- Counters:
  - `baud_cnt` is 16 bits. It counts 0..`BAUD_DIV-1`; the bit ends when `baud_cnt==BAUD_DIV-1`, and the counter then returns to 0.
  - `bit_idx` is 3 bits and counts 0..7. It does not wrap past 7 within a frame.
- `rdreq` is asserted only in READ, which is entered only when `empty==0` was sampled in IDLE. The block therefore never reads an empty FIFO.
- `empty` is ignored outside IDLE. Bytes arriving mid-frame wait in the FIFO.
- Reset (active on any cycle, including mid-frame), effective at the next edge:
  - State returns to IDLE; `tx=1`, `rdreq=0`, `busy=0`, `frame_done=0`; counters and shift register are cleared.
  - A partially sent byte is discarded, not resent.

## Timing

- Reset values: `tx=1`, `rdreq=0`, `busy=0`, `frame_done=0`.
- Start-of-frame latency: IDLE samples `empty==0` at edge k. Then:
  - `rdreq` is high between edge k and edge k+1.
  - The shift register loads, and `tx` falls, at edge k+2.
- Frame length: `tx` is low from the start edge for exactly `BAUD_DIV` cycles. Each data bit lasts `BAUD_DIV` cycles. The stop bit lasts `BAUD_DIV` cycles. Total is `10*BAUD_DIV`, or `11*BAUD_DIV` with parity.
- `frame_done` is high for the single cycle after the last stop-bit count, coincident with the return to IDLE.
- Back-to-back bytes (`empty` stays 0): `tx` stays high for `BAUD_DIV+3` cycles between the last data bit and the next start bit. The next `rdreq` is exactly 1 cycle after `frame_done`.
- Maximum read rate is one `rdreq` per `10*BAUD_DIV+3` cycles.

## Configuration

- `UART_TX_PARITY_EN`:
  - When defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for `BAUD_DIV` cycles. The frame becomes 8E1, 11 bits.
  - When undefined: no PARITY state. The frame is 8N1, 10 bits, and all timing above applies unchanged.

## Test plan

All scenarios use `BAUD_DIV=4`.

- **Single byte.** Drive `empty=0` for 1 byte with `q=0x55`.
  - `rdreq` is high for exactly 1 cycle.
  - `tx` is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - `frame_done` pulses once, 40 cycles after `tx` falls.
- **Terminator pair.** Queue `0x0d` then `0x0a`.
  - Two frames decode LSB-first as 0x0d and 0x0a.
  - The idle gap between the end of frame 1's last data bit and frame 2's start bit is 7 cycles.
  - Exactly 2 `rdreq` pulses.
- **Empty hold.** Hold `empty=1` for 1000 cycles.
  - `rdreq` never asserts; `tx=1` and `busy=0` throughout.
- **Reset mid-frame.** Assert `reset` during data bit 3 of 0xA3.
  - The next edge gives `tx=1`, `busy=0`, `rdreq=0`.
  - After release with `empty=1`, no frame is emitted.
- **Reset during READ.** Assert `reset` in the cycle `rdreq=1`.
  - `rdreq=0` at the next edge; no frame is started.
- **Parity (`UART_TX_PARITY_EN` defined).** Send 0x07.
  - The parity bit is 1, the frame is 44 cycles long, and `frame_done` pulses at the end of the stop bit.
